cordic_engine_pp: RTL and testbench

Parametrised, fully pipelined CORDIC engine and successor to the fixed 10-stage sine/cosine pipeline. It supports rotation mode (sin/cos, vector rotation) and vectoring mode (magnitude/atan2) selected per sample. It covers the full ±π angle range through a quadrant pre-fold stage. It adds valid/ready backpressure and output saturation, and sits between angle/vector producers and the DSP datapath in the MathFunction library.

---
 rtl/cordic_engine_pp.sv | 234 +++++++++++++++++++++++
 tb/tb_cordic_engine_pp.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine_pp.sv
// Pipelined CORDIC engine: quadrant fold, STAGES micro-rotations, saturation.
// Define CORDIC_GAIN_COMP_EN to add a K-scaling stage after saturation.
module cordic_engine_pp #(
    parameter int SYM_WIDTH = 1,
    parameter int INT_WIDTH = 2,
    parameter int DEC_WIDTH = 14,
    parameter int STAGES    = 12,
    localparam int W = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    input  logic signed [W-1:0] in_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic signed [W-1:0] out_x,
    output logic signed [W-1:0] out_y,
    output logic signed [W-1:0] out_z
);

    // Two guard bits: a full-scale vector reaches sqrt(2)*1.6468 of range.
    localparam int XW = W + 2;

    typedef struct packed {
        logic          v;
        logic          m;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [W-1:0]  z;
    } stg_t;

    function automatic longint unsigned atan_q30(input int i);
        case (i)
            0:  return 64'd843314857;
            1:  return 64'd497837829;
            2:  return 64'd263043836;
            3:  return 64'd133525158;
            4:  return 64'd67021686;
            5:  return 64'd33543515;
            6:  return 64'd16775850;
            7:  return 64'd8388437;
            8:  return 64'd4194282;
            9:  return 64'd2097149;
            10: return 64'd1048575;
            11: return 64'd524287;
            12: return 64'd262143;
            13: return 64'd131071;
            14: return 64'd65535;
            15: return 64'd32767;
            16: return 64'd16383;
            17: return 64'd8191;
            18: return 64'd4095;
            19: return 64'd2047;
            20: return 64'd1023;
            21: return 64'd511;
            22: return 64'd255;
            23: return 64'd127;
            24: return 64'd63;
            25: return 64'd31;
            26: return 64'd15;
            27: return 64'd7;
            28: return 64'd3;
            29: return 64'd1;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] q_round(input longint unsigned v);
        int sh = 30 - DEC_WIDTH;
        longint unsigned r;
        if (sh == 0) r = v;
        else r = (v + (64'd1 << (sh - 1))) >> sh;
        return r[W-1:0];
    endfunction

    function automatic stg_t rot(input stg_t s, input int i);
        logic signed [XW-1:0] xs;
        logic signed [XW-1:0] ys;
        logic signed [W-1:0]  zs;
        logic signed [W-1:0]  a;
        logic                 d;
        stg_t                 r;
        xs = s.x;
        ys = s.y;
        zs = s.z;
        a  = q_round(atan_q30(i));
        d  = s.m ? ys[XW-1] : !zs[W-1];
        r  = s;
        if (d) begin
            r.x = xs - (ys >>> i);
            r.y = ys + (xs >>> i);
            r.z = zs - a;
        end else begin
            r.x = xs + (ys >>> i);
            r.y = ys - (xs >>> i);
            r.z = zs + a;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] sat(input logic [XW-1:0] v);
        logic [XW-W:0] top;
        top = v[XW-1:W-1];
        if (top == '0 || top == '1) return v[W-1:0];
        return v[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    localparam logic signed [W-1:0] P2 = q_round(64'd1686629713);
    localparam logic signed [W-1:0] N2 = -P2;

    logic                 en;
    logic signed [XW-1:0] ix;
    logic signed [XW-1:0] iy;
    stg_t                 fold;
    stg_t                 pipe [STAGES+1];
    stg_t                 nxt  [STAGES];
    logic                 ov;
    logic                 om;
    logic [W-1:0]         ox;
    logic [W-1:0]         oy;
    logic [W-1:0]         oz;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        ix     = XW'(in_x);
        iy     = XW'(in_y);
        fold.v = in_valid;
        fold.m = in_mode;
        fold.x = ix;
        fold.y = iy;
        fold.z = in_z;
        unique case (1'b1)
            !in_mode && (in_z > P2): begin
                fold.x = -iy;
                fold.y = ix;
                fold.z = in_z - P2;
            end
            !in_mode && (in_z < N2): begin
                fold.x = iy;
                fold.y = -ix;
                fold.z = in_z + P2;
            end
            in_mode && ix[XW-1] && !iy[XW-1]: begin
                fold.x = iy;
                fold.y = -ix;
                fold.z = in_z + P2;
            end
            in_mode && ix[XW-1] && iy[XW-1]: begin
                fold.x = -iy;
                fold.y = ix;
                fold.z = in_z - P2;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) nxt[i] = rot(pipe[i], i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= STAGES; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= fold;
            for (int i = 0; i < STAGES; i++) pipe[i+1] <= nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ov <= 1'b0;
            om <= 1'b0;
            ox <= '0;
            oy <= '0;
            oz <= '0;
        end else if (en) begin
            ov <= pipe[STAGES].v;
            om <= pipe[STAGES].m;
            ox <= sat(pipe[STAGES].x);
            oy <= sat(pipe[STAGES].y);
            oz <= pipe[STAGES].z;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // K ~ 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13, each term truncated
    function automatic logic [W-1:0] kmul(input logic signed [W-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
    endfunction

    logic         gv;
    logic         gm;
    logic [W-1:0] gx;
    logic [W-1:0] gy;
    logic [W-1:0] gz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gv <= 1'b0;
            gm <= 1'b0;
            gx <= '0;
            gy <= '0;
            gz <= '0;
        end else if (en) begin
            gv <= ov;
            gm <= om;
            gx <= kmul(ox);
            gy <= kmul(oy);
            gz <= oz;
        end
    end

    assign out_valid = gv;
    assign out_mode  = gm;
    assign out_x     = gx;
    assign out_y     = gy;
    assign out_z     = gz;
`else
    assign out_valid = ov;
    assign out_mode  = om;
    assign out_x     = ox;
    assign out_y     = oy;
    assign out_z     = oz;
`endif

endmodule

// File: tb/tb_cordic_engine_pp.sv
// Scoreboard bench for cordic_engine_pp against a floating-point model.
// Honours CORDIC_GAIN_COMP_EN for latency and output scaling.
module tb_cordic_engine_pp;

    localparam int DEC = 14;
    localparam int STG = 12;
    localparam int W   = 17;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  L  = STG + 3;
    localparam real KC = 0.5 + 0.125 - 1.0/64 - 1.0/512 - 1.0/8192;
`else
    localparam int  L  = STG + 2;
    localparam real KC = 1.0;
`endif

    logic                clk;
    logic                rstn;
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic signed [W-1:0] in_x;
    logic signed [W-1:0] in_y;
    logic signed [W-1:0] in_z;
    logic                out_valid;
    logic                out_ready;
    logic                out_mode;
    logic signed [W-1:0] out_x;
    logic signed [W-1:0] out_y;
    logic signed [W-1:0] out_z;

    cordic_engine_pp #(
        .SYM_WIDTH(1),
        .INT_WIDTH(2),
        .DEC_WIDTH(DEC),
        .STAGES(STG)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .in_x(in_x),
        .in_y(in_y),
        .in_z(in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode(out_mode),
        .out_x(out_x),
        .out_y(out_y),
        .out_z(out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit  m;
        real ex;
        real ey;
        real ez;
        real txy;
        real tz;
        int  cyc;
        bit  lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   lat_next = 0;
    int   bp_t = 0;
    int   bp_a = 1;
    int   bp_b = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_int(input string nm, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    task automatic chk_real(input string nm, input real got, input real want, input real tol);
        real d;
        d = got - want;
        if (d < 0.0) d = -d;
        n_chk++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0.1f want %0.1f tol %0.1f", nm, got, want, tol);
    endtask

    function automatic real clampr(input real v, input real lo, input real hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Ideal CORDIC result: rotation or polar conversion with gain K
    function automatic exp_t model(input bit m, input int x, input int y, input int z);
        exp_t e;
        real  k, p, sc, r, ang, lim;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < STG; i++) begin
            k = k * $sqrt(1.0 + p * p);
            p = p / 2.0;
        end
        sc  = real'(1 << DEC);
        lim = real'(1 << (W - 1));
        r   = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.m = m;
        if (!m) begin
            ang  = real'(z) / sc;
            e.ex = k * (real'(x) * $cos(ang) - real'(y) * $sin(ang));
            e.ey = k * (real'(x) * $sin(ang) + real'(y) * $cos(ang));
            e.ez = 0.0;
            e.tz = 24.0;
        end else begin
            e.ex = k * r;
            e.ey = 0.0;
            e.ez = real'(z) + $atan2(real'(y), real'(x)) * sc;
            e.tz = 24.0 + sc * 16.0 / (r < 1.0 ? 1.0 : r);
        end
        e.ex  = KC * clampr(e.ex, -lim, lim - 1.0);
        e.ey  = KC * clampr(e.ey, -lim, lim - 1.0);
        e.txy = 16.0 + k * r / real'(1 << (STG - 2));
        e.cyc = 0;
        e.lat = 0;
        return e;
    endfunction

    task automatic drive_cycle(input bit v, input bit m, input int x, input int y,
                               input int z, input bit rdy, output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_mode   = m;
        in_x      = x[W-1:0];
        in_y      = y[W-1:0];
        in_z      = z[W-1:0];
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e        = model(m, x, y, z);
            e.cyc    = cyc;
            e.lat    = lat_next;
            lat_next = 0;
            q.push_back(e);
        end
    endtask

    task automatic send(input bit m, input int x, input int y, input int z, input int pct);
        bit acc;
        bit rdy;
        int g;
        g = 0;
        do begin
            rdy = (bp_t < bp_a || bp_t > bp_b) && ($urandom_range(99) < pct);
            drive_cycle(1'b1, m, x, y, z, rdy, acc);
            bp_t++;
            g++;
        end while (!acc && g < 1000);
        chk_int("accept", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, acc);
    endtask

    task automatic rand_send(input int pct);
        bit m;
        int x, y, z;
        real r;
        m = 1'($urandom_range(1));
        do begin
            x = int'($urandom_range(52000)) - 26000;
            y = int'($urandom_range(52000)) - 26000;
            r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        end while (r < 4096.0);
        z = m ? 0 : int'($urandom_range(102942)) - 51471;
        send(m, x, y, z, pct);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 500) begin
            idle(1);
            g++;
        end
        chk_int("drain", q.size(), 0);
    endtask

    // Monitor: handshake rule every cycle, scoreboard pop on each output transfer
    initial forever begin
        exp_t e;
        real  tw, zw;
        @(negedge clk);
        if (rstn) begin
            chk_int("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk_int("unexpected_out_valid", out_valid, 0);
                end else begin
                    e  = q.pop_front();
                    tw = 2.0 * 3.14159265358979 * real'(1 << DEC);
                    zw = e.ez + tw * $floor((real'(out_z) - e.ez) / tw + 0.5);
                    chk_real("out_x", real'(out_x), e.ex, e.txy);
                    chk_real("out_y", real'(out_y), e.ey, e.txy);
                    chk_real("out_z", real'(out_z), zw, e.tz);
                    chk_int("out_mode", out_mode, e.m);
                    if (e.lat) chk_int("latency", cyc - e.cyc, L);
                end
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("rst_out_valid", out_valid, 0);
        chk_int("rst_out_x", out_x, 0);
        chk_int("rst_out_y", out_y, 0);
        chk_int("rst_out_z", out_z, 0);
        chk_int("rst_out_mode", out_mode, 0);
        chk_int("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        lat_next = 1;
        send(1'b0, 9949, 0, 8579, 100);
        send(1'b0, 9949, 0, 38603, 100);
        send(1'b0, 9949, 0, -38603, 100);
        send(1'b1, -16384, 0, 0, 100);
        send(1'b1, 16384, 16384, 0, 100);
        send(1'b0, 16384, 5000, 25736, 100);
        send(1'b0, -12000, 7000, -25736, 100);
        send(1'b1, -20000, -9000, 0, 100);
        send(1'b1, 65535, 65535, 0, 100);
        drain();

        bp_t = 0;
        bp_a = 16;
        bp_b = 20;
        repeat (20) rand_send(100);
        bp_a = 1;
        bp_b = 0;
        drain();

        repeat (150) begin
            if ($urandom_range(9) < 2) idle(1);
            rand_send(70);
        end
        drain();

        repeat (8) rand_send(100);
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_int("midrst_out_valid", out_valid, 0);
        chk_int("midrst_out_x", out_x, 0);
        chk_int("midrst_out_y", out_y, 0);
        chk_int("midrst_out_z", out_z, 0);
        chk_int("midrst_out_mode", out_mode, 0);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < L + 4; i++) begin
            idle(1);
            chk_int("post_rst_valid", out_valid, 0);
        end

        lat_next = 1;
        rand_send(100);
        repeat (30) rand_send(80);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
